// File: rtl/half_word_packer.sv
// half_word_packer: repacks a stream of full/half beats into full output
// words, carrying a pending half across word boundaries. A flush emits a
// lone pending half as a partial word; a wrapping counter tracks transfers.
module half_word_packer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_full,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_partial,
  output logic               idle,
  output logic [COUNT_W-1:0] word_count
);

  localparam int H = DATA_W / 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t            state;
  logic [H-1:0]      hold;

  logic              load_free;
  logic              accept;
  logic              transfer;
  logic              flush_load;
  logic [H-1:0]      in_lo;
  logic [H-1:0]      in_hi;
  logic [DATA_W-1:0] pair_half;
  logic [DATA_W-1:0] pair_full;
  logic [DATA_W-1:0] flush_word;
  logic [H-1:0]      hold_after_full;

  // The output register may be reloaded when empty or being drained this cycle.
  assign load_free  = !out_valid || out_ready;
  assign in_ready   = load_free && !flush;
  assign accept     = in_valid && in_ready;
  assign transfer   = out_valid && out_ready;
  assign flush_load = flush && (state == HALF) && load_free;
  assign idle       = (state == EMPTY) && !out_valid;

  assign in_lo = in_data[H-1:0];
  assign in_hi = in_data[DATA_W-1:H];

  // Word formation depends on which half of a word arrives first. For a full
  // beat in HALF, the half that arrives first completes the current word and
  // the other one becomes the new pending half.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign pair_half       = {hold, in_lo};
      assign pair_full       = {hold, in_hi};
      assign hold_after_full = in_lo;
      assign flush_word      = {hold, {H{1'b0}}};
    end else begin : g_lsb_first
      assign pair_half       = {in_lo, hold};
      assign pair_full       = {in_lo, hold};
      assign hold_after_full = in_hi;
      assign flush_word      = {{H{1'b0}}, hold};
    end
  endgenerate

  // Packing FSM with registered outputs and the transfer counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      hold        <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
      word_count  <= '0;
    end else begin
      if (transfer) begin
        word_count <= word_count + COUNT_W'(1);
        // Cleared here; any load below in the same cycle overrides it.
        out_valid  <= 1'b0;
      end

      if (accept) begin
        case (state)
          EMPTY: begin
            if (in_full) begin
              out_data    <= in_data;
              out_valid   <= 1'b1;
              out_partial <= 1'b0;
            end else begin
              hold  <= in_lo;
              state <= HALF;
            end
          end
          HALF: begin
            out_valid   <= 1'b1;
            out_partial <= 1'b0;
            if (in_full) begin
              out_data <= pair_full;
              hold     <= hold_after_full;
            end else begin
              out_data <= pair_half;
              state    <= EMPTY;
            end
          end
          default: state <= EMPTY;
        endcase
      end else if (flush_load) begin
        out_data    <= flush_word;
        out_valid   <= 1'b1;
        out_partial <= 1'b1;
        state       <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_half_word_packer.sv
// Testbench for half_word_packer: two instances (MSB-first with 16-bit count,
// LSB-first with 2-bit count) driven by the same directed stimulus, checked
// every cycle against a half-stream model plus literal word expectations.
`timescale 1ns/1ps
module tb_half_word_packer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_full;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_partial_a, idle_a;
  logic [7:0]  out_data_a;
  logic [15:0] word_count_a;
  logic        in_ready_b, out_valid_b, out_partial_b, idle_b;
  logic [7:0]  out_data_b;
  logic [1:0]  word_count_b;

  int tests = 0;
  int fails = 0;
  logic run_chk = 1'b0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  half_word_packer #(.DATA_W(8), .MSB_FIRST(1'b1), .COUNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_full(in_full),
    .in_data(in_data), .in_ready(in_ready_a), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_partial(out_partial_a), .idle(idle_a), .word_count(word_count_a)
  );

  half_word_packer #(.DATA_W(8), .MSB_FIRST(1'b0), .COUNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_full(in_full),
    .in_data(in_data), .in_ready(in_ready_b), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_partial(out_partial_b), .idle(idle_b), .word_count(word_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The input is viewed as a stream of halves; every two halves make a word.
  typedef struct packed {
    logic        valid;
    logic [7:0]  data;
    logic        part;
    logic [15:0] cnt;
    logic        npend;
    logic [3:0]  pend;
  } mstate_t;

  mstate_t ms [2];

  // Instance 0 puts the first half on top, instance 1 at the bottom.
  function automatic logic [7:0] pack2(input int i, input logic [3:0] first, input logic [3:0] second);
    return (i == 0) ? {first, second} : {second, first};
  endfunction

  function automatic mstate_t model_step(input int i, input mstate_t s, input logic v,
                                         input logic f, input logic [7:0] d,
                                         input logic rdy, input logic fl);
    mstate_t    n;
    logic [3:0] hv [3];
    int         cnt;
    logic       free;
    logic       acc;
    n     = s;
    hv[0] = 4'h0; hv[1] = 4'h0; hv[2] = 4'h0;
    free  = !s.valid || rdy;
    acc   = v && free && !fl;
    cnt   = 0;
    if (s.npend) begin
      hv[0] = s.pend;
      cnt   = 1;
    end
    if (acc) begin
      if (f) begin
        hv[cnt]     = (i == 0) ? d[7:4] : d[3:0];
        hv[cnt + 1] = (i == 0) ? d[3:0] : d[7:4];
        cnt += 2;
      end else begin
        hv[cnt] = d[3:0];
        cnt += 1;
      end
    end
    if (s.valid && rdy) begin
      n.cnt   = 16'(s.cnt + 16'd1);
      n.valid = 1'b0;
    end
    if (cnt >= 2) begin
      n.valid = 1'b1;
      n.data  = pack2(i, hv[0], hv[1]);
      n.part  = 1'b0;
      n.npend = (cnt == 3);
      if (cnt == 3) n.pend = hv[2];
    end else if (cnt == 1 && fl && free) begin
      n.valid = 1'b1;
      n.data  = (i == 0) ? {hv[0], 4'h0} : {4'h0, hv[0]};
      n.part  = 1'b1;
      n.npend = 1'b0;
    end else begin
      n.npend = (cnt == 1);
      if (cnt == 1) n.pend = hv[0];
    end
    return n;
  endfunction

  // Model update on every clock, cleared by the asynchronous reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms[0] <= '0;
      ms[1] <= '0;
    end else begin
      ms[0] <= model_step(0, ms[0], in_valid, in_full, in_data, out_ready, flush);
      ms[1] <= model_step(1, ms[1], in_valid, in_full, in_data, out_ready, flush);
    end
  end

  // Per-cycle comparison against the model, plus a log of transferred words.
  always @(negedge clk) begin
    if (reset_n && run_chk) begin
      chk("a_valid", 32'(out_valid_a), 32'(ms[0].valid));
      chk("b_valid", 32'(out_valid_b), 32'(ms[1].valid));
      chk("a_ready", 32'(in_ready_a), 32'((!ms[0].valid || out_ready) && !flush));
      chk("b_ready", 32'(in_ready_b), 32'((!ms[1].valid || out_ready) && !flush));
      chk("a_idle", 32'(idle_a), 32'(!ms[0].npend && !ms[0].valid));
      chk("b_idle", 32'(idle_b), 32'(!ms[1].npend && !ms[1].valid));
      chk("a_count", 32'(word_count_a), 32'(ms[0].cnt));
      chk("b_count", 32'(word_count_b), 32'(ms[1].cnt[1:0]));
      if (ms[0].valid) begin
        chk("a_data", 32'(out_data_a), 32'(ms[0].data));
        chk("a_partial", 32'(out_partial_a), 32'(ms[0].part));
      end
      if (ms[1].valid) begin
        chk("b_data", 32'(out_data_b), 32'(ms[1].data));
        chk("b_partial", 32'(out_partial_b), 32'(ms[1].part));
      end
      if (out_valid_a && out_ready) qa.push_back({out_partial_a, out_data_a});
      if (out_valid_b && out_ready) qb.push_back({out_partial_b, out_data_b});
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic full, input logic [7:0] d);
    int   t;
    logic ok;
    t        = 0;
    in_valid = 1'b1;
    in_full  = full;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready_a;
      t++;
    end while (!ok && t < 50);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for data %0h", d);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pops one logged word from each instance and compares with literals.
  task automatic pop_chk(input string name, input logic [8:0] exp_a, input logic [8:0] exp_b);
    if (qa.size() == 0) chk({name, "_a_missing"}, 32'(qa.size()), 32'd1);
    else chk({name, "_a"}, 32'(qa.pop_front()), 32'(exp_a));
    if (qb.size() == 0) chk({name, "_b_missing"}, 32'(qb.size()), 32'd1);
    else chk({name, "_b"}, 32'(qb.pop_front()), 32'(exp_b));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_a_valid"}, 32'(out_valid_a), 32'd0);
    chk({name, "_a_data"}, 32'(out_data_a), 32'd0);
    chk({name, "_a_partial"}, 32'(out_partial_a), 32'd0);
    chk({name, "_a_count"}, 32'(word_count_a), 32'd0);
    chk({name, "_a_idle"}, 32'(idle_a), 32'd1);
    chk({name, "_a_ready"}, 32'(in_ready_a), 32'd1);
    chk({name, "_b_valid"}, 32'(out_valid_b), 32'd0);
    chk({name, "_b_count"}, 32'(word_count_b), 32'd0);
    chk({name, "_b_idle"}, 32'(idle_b), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_full = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1 chk_reset_outputs("reset");
    run_chk = 1'b1;
    @(posedge clk); #1;

    // Two full beats back to back.
    send(1'b1, 8'hA5);
    send(1'b1, 8'h3C);
    wait_cycles(3);
    pop_chk("full1", 9'h0A5, 9'h0A5);
    pop_chk("full2", 9'h03C, 9'h03C);
    chk("count_after_full", 32'(word_count_a), 32'd2);

    // Two halves make one word; order depends on MSB_FIRST.
    send(1'b0, 8'hFA);
    send(1'b0, 8'h0B);
    wait_cycles(3);
    pop_chk("halves", 9'h0AB, 9'h0BA);

    // Half, full, half: realignment through a full beat.
    send(1'b0, 8'h0A);
    chk("half_pending_idle", 32'(idle_a), 32'd0);
    send(1'b1, 8'hBC);
    send(1'b0, 8'h0D);
    wait_cycles(3);
    chk("realign_end_idle", 32'(idle_a), 32'd1);
    pop_chk("realign1", 9'h0AB, 9'h0CA);
    pop_chk("realign2", 9'h0CD, 9'h0DB);

    // Back-pressure with the next beat held on the input.
    send(1'b1, 8'h11);
    out_ready = 1'b0; in_valid = 1'b1; in_full = 1'b1; in_data = 8'h22;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready_a), 32'd0);
      chk("bp_data", 32'(out_data_a), 32'h11);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_cycles(3);
    pop_chk("bp1", 9'h011, 9'h011);
    pop_chk("bp2", 9'h022, 9'h022);

    // Flush of a trailing half, then a flush with nothing pending.
    send(1'b0, 8'h0E);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_input", 32'(in_ready_a), 32'd0);
    wait_cycles(3);
    flush = 1'b0;
    wait_cycles(2);
    pop_chk("flush", 9'h1E0, 9'h10E);
    flush = 1'b1;
    wait_cycles(3);
    flush = 1'b0;
    wait_cycles(2);
    chk("empty_flush_count", 32'(word_count_a), 32'd8);
    chk("empty_flush_no_word", 32'(qa.size()), 32'd0);

    // Reset asynchronously while HALF with a stalled output word.
    send(1'b0, 8'h07);
    out_ready = 1'b0;
    send(1'b1, 8'h55);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    wait_cycles(1);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b1, 8'hF0);
    send(1'b1, 8'hF1);
    send(1'b1, 8'hF2);
    send(1'b1, 8'hF3);
    wait_cycles(3);
    pop_chk("post_reset", 9'h012, 9'h021);
    pop_chk("post_f0", 9'h0F0, 9'h0F0);
    pop_chk("post_f1", 9'h0F1, 9'h0F1);
    pop_chk("post_f2", 9'h0F2, 9'h0F2);
    pop_chk("post_f3", 9'h0F3, 9'h0F3);
    chk("count16_after_5", 32'(word_count_a), 32'd5);
    chk("count2_wrap", 32'(word_count_b), 32'd1);

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/half_word_packer.md
# half_word_packer

Parametrised successor to the team's byte/nibble transfer stage. Accepts a stream of DATA_W-bit beats, each tagged as a full word or a half word (lower DATA_W/2 bits). Repacks them into full DATA_W-bit output words, realigning across half-word boundaries. Uses valid/ready handshakes on both sides, supports a flush for a trailing half word, and keeps a wrapping output-word count. Sits between a narrow/mixed-width source (serial deserialiser, nibble bus) and the byte-wide FIFO write port.

## Interface
Parameters:
- DATA_W, 8, beat and output word width; even, ≥2; H = DATA_W/2.
- MSB_FIRST, 1, 1: first-arriving half occupies the upper half of an output word; 0: the lower half.
- COUNT_W, 16, width of the output word counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat present.
- in_full  input  1  1 = full word beat; 0 = half beat, data in in_data[H-1:0], upper bits ignored.
- in_data  input  DATA_W  beat data.
- in_ready  output  1  combinational: (!out_valid | out_ready) & !flush.
- flush  input  1  level request to emit a pending half word; blocks input while high.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  packed word.
- out_partial  output  1  qualifies out_data; 1 = flushed word, only the first half valid, other half zero.
- idle  output  1  state EMPTY and !out_valid.
- word_count  output  COUNT_W  number of words transferred (out_valid & out_ready), wraps modulo 2^COUNT_W.

## Operation
- Accept = in_valid & in_ready. Output register load allowed when !out_valid | out_ready.
- State EMPTY: no half pending. State HALF: H-bit hold register pending.
- Notation for MSB_FIRST=1: in the HALF state, a half-beat load and a full-beat load are formed as follows.

Transitions on accept:
- EMPTY, full: out_data <= in_data; out_valid <= 1; stay EMPTY.
- EMPTY, half: hold <= in_data[H-1:0]; go to HALF; no output.
- HALF, half: out_data <= {hold, in_data[H-1:0]}; out_valid <= 1; go to EMPTY.
- HALF, full: out_data <= {hold, in_data[DATA_W-1:H]}; hold <= in_data[H-1:0]; out_valid <= 1; stay HALF.
- MSB_FIRST=0, HALF, half: out_data <= {in_data[H-1:0], hold}.
- MSB_FIRST=0, HALF, full: out_data <= {in_data[H-1:0], hold}; hold <= in_data[DATA_W-1:H].

Flush:
- Flush in HALF with the output register free: out_data <= {hold, H'b0} (MSB_FIRST=1) or {H'b0, hold} (MSB_FIRST=0); out_partial <= 1; out_valid <= 1; go to EMPTY.
- Flush in EMPTY: no effect.
- Flush remains level; in_ready is 0 while flush is high, so flush never coincides with an accept.

Other behaviour:
- out_partial <= 0 on every non-flush load.
- out_valid clears on transfer when there is no new load.
- out_data, out_valid and out_partial hold stable while out_valid & !out_ready.
- word_count increments on each out_valid & out_ready, including partial words.

## Timing
- Reset values:
  - out_data 0, out_valid 0, out_partial 0, word_count 0, hold 0, state EMPTY.
  - idle 1; in_ready 1 if flush=0.
- Latency: the word completes on the accept edge; out_valid is high the following cycle.
- Throughput: one beat per cycle with out_ready held high.
- Sustained full beats in HALF produce one word per beat, with the realignment carried indefinitely.
- Back-pressure: when out_valid=1 and out_ready=0, in_ready=0 the same cycle and no state changes.
- Simultaneous transfer and accept in the same cycle: out_valid stays 1 with new data and word_count increments.
- Reset mid-operation clears the hold register and state; a pending half is discarded, not emitted.
- word_count wraps from 2^COUNT_W-1 to 0.

## Test plan
- DATA_W=8, MSB_FIRST=1, out_ready=1. Full beats 0xA5, 0x3C on consecutive cycles -> out_data 0xA5 then 0x3C, one cycle after each accept; word_count=2.
- Half beats 0x0A, 0x0B -> single word 0xAB, out_partial=0. Repeat with MSB_FIRST=0 -> 0xBA.
- Half 0x0A, full 0xBC, half 0x0D -> words 0xAB then 0xCD; state HALF between them; idle=1 at end.
- out_ready=0 after full 0x11 is accepted -> out_data stays 0x11 and in_ready=0 for 5 cycles with in_valid held (data 0x22). Release -> 0x11 transfers, then 0x22 next cycle, no loss or duplication.
- Half 0x0E then flush=1 -> out_data 0xE0, out_partial=1, in_ready=0 during flush. Flush again in EMPTY -> no output, word_count unchanged.
- reset_n pulsed low asynchronously while in HALF with out_valid=1 -> all outputs at reset values immediately. Subsequent halves 0x01, 0x02 -> 0x12. With COUNT_W=2, 5 words -> word_count=1.
